// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage valid/ready register pipeline with bubble collapsing and flush.
// Define ELASTIC_PIPE_OCCUPANCY_EN to add the occupancy output (popcount of stage valid bits).
module elastic_pipe_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] move;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] data    [DEPTH];
    logic [WIDTH-1:0] up_data [DEPTH];
    logic             m;

    // Resolve movement from the output end backwards so a stage may advance into a slot being vacated.
    always_comb begin
        m = valid[DEPTH-1] & out_ready;
        move = '0;
        move[DEPTH-1] = m;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            m = valid[k] & (~valid[k+1] | m);
            move[k] = m;
        end
        ready = ~valid | move;
    end

    always_comb begin
        up_valid = '0;
        up_valid[0] = in_valid;
        up_data[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_valid[k] = valid[k-1];
            up_data[k] = data[k-1];
        end
    end

    assign in_ready  = ready[0] & ~flush & ~rst;
    assign out_valid = valid[DEPTH-1] & ~flush;
    assign out_data  = data[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int k = 0; k < DEPTH; k++) data[k] <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (ready[k]) begin
                    valid[k] <= up_valid[k];
                    if (up_valid[k]) data[k] <= up_data[k];
                end
            end
        end
    end

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) occupancy = occupancy + ($clog2(DEPTH+1))'(valid[k]);
    end
`endif
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: directed self-checking bench for elastic_pipe_reg (WIDTH=8, DEPTH=4).
module tb_elastic_pipe_reg;
    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    int         checks = 0;
    int         errors = 0;
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    logic [2:0] occupancy;
`endif

    elastic_pipe_reg #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        , .occupancy(occupancy)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        rst = 1; flush = 0; in_valid = 1; in_data = 8'hAA; out_ready = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready0: got %b exp 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready1: got %b exp 0", in_ready); end
        @(negedge clk);
        rst = 0; in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h exp 00", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_rel: got %b exp 1", in_ready); end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", occupancy); end
`endif
        @(negedge clk);
    endtask

    task automatic test_streaming;
        out_ready = 1;
        for (int t = 0; t < 12; t++) begin
            in_valid = (t < 8);
            in_data = 8'(t + 1);
            #1;
            if (t < 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready t=%0d: got %b exp 1", t, in_ready); end
            end
            checks++; if (out_valid !== (t >= 4)) begin errors++; $display("FAIL stream_out_valid t=%0d: got %b exp %b", t, out_valid, t >= 4); end
            if (t >= 4) begin
                checks++; if (out_data !== 8'(t - 3)) begin errors++; $display("FAIL stream_out_data t=%0d: got %h exp %h", t, out_data, 8'(t - 3)); end
            end
            @(negedge clk);
        end
        in_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int idx = 0;
        logic [7:0] exp = 8'h10;
        out_ready = 0;
        for (int t = 0; t < 8; t++) begin
            in_valid = 1; in_data = 8'(8'h10 + idx);
            #1;
            if (in_ready) idx++;
            @(negedge clk);
        end
        in_data = 8'(8'h10 + idx);
        #1;
        checks++; if (idx !== 4) begin errors++; $display("FAIL bp_accepted: got %0d exp 4", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
        checks++; if (out_data !== 8'h10 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got %b/%h exp 1/10", out_valid, out_data); end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occ: got %0d exp 4", occupancy); end
`endif
        for (int t = 0; t < 16; t++) begin
            out_ready = 1; in_valid = (idx < 6); in_data = 8'(8'h10 + idx);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                checks++; if (out_data !== exp) begin errors++; $display("FAIL bp_order: got %h exp %h", out_data, exp); end
                exp++;
            end
            @(negedge clk);
        end
        checks++; if (exp !== 8'h16) begin errors++; $display("FAIL bp_count: got %h exp 16", exp); end
        in_valid = 0;
    endtask

    task automatic test_bubble;
        out_ready = 0; in_valid = 1; in_data = 8'h21;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1; in_data = 8'h22;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_in_ready: got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin errors++; $display("FAIL bub_head: got %b/%h exp 1/21", out_valid, out_data); end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL bub_occ: got %0d exp 2", occupancy); end
`endif
        out_ready = 1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin errors++; $display("FAIL bub_second: got %b/%h exp 1/22", out_valid, out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h22) begin errors++; $display("FAIL bub_empty_hold: got %b/%h exp 0/22", out_valid, out_data); end
    endtask

    task automatic test_flush;
        out_ready = 0;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1; in_data = 8'(8'h31 + t);
            @(negedge clk);
        end
        in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin errors++; $display("FAIL fl_pre: got %b/%h exp 1/31", out_valid, out_data); end
        flush = 1; in_valid = 1; in_data = 8'h99; out_ready = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready: got %b exp 0", in_ready); end
        @(negedge clk);
        flush = 0; in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h31) begin errors++; $display("FAIL fl_after: got %b/%h exp 0/31", out_valid, out_data); end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fl_occ: got %0d exp 0", occupancy); end
`endif
        in_valid = 1; in_data = 8'h55;
        @(negedge clk);
        in_valid = 0;
        for (int j = 0; j < 6; j++) begin
            checks++; if (out_valid !== (j == 3)) begin errors++; $display("FAIL fl_lat j=%0d: got %b exp %b", j, out_valid, j == 3); end
            if (j == 3) begin
                checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL fl_data: got %h exp 55", out_data); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_and_reset;
        out_ready = 0;
        for (int t = 0; t < 4; t++) begin
            in_valid = 1; in_data = 8'(8'h40 + t);
            @(negedge clk);
        end
        out_ready = 1;
        for (int t = 0; t < 4; t++) begin
            in_valid = 1; in_data = 8'(8'h44 + t);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready t=%0d: got %b exp 1", t, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(8'h40 + t)) begin errors++; $display("FAIL full_order t=%0d: got %b/%h exp 1/%h", t, out_valid, out_data, 8'(8'h40 + t)); end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
            checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ t=%0d: got %0d exp 4", t, occupancy); end
`endif
            @(negedge clk);
        end
        rst = 1; in_data = 8'h77;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b exp 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_out: got %b/%h exp 0/00", out_valid, out_data); end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_mid_occ: got %0d exp 0", occupancy); end
`endif
        rst = 0; in_valid = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release: got %b exp 1", in_ready); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_full_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised successor to the single D flip-flop.
- A chain of DEPTH edge-triggered WIDTH-bit register stages with per-stage valid bits and a valid/ready handshake on both ends.
- Supports stall (backpressure), bubble collapsing and synchronous flush.
- Used as the standard retiming/buffering stage between synchronous datapath blocks.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)

Ports:
- clk  input  1  rising-edge clock, only clock in the block
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline clear; discards all in-flight words
- in_valid  input  1  upstream word present
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  word present at output (valid of stage DEPTH-1)
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  data of stage DEPTH-1

Behaviour:
- One clock (clk); reset rst is synchronous and active-high; sampled on rising clk edge only.
- Stage state: valid[k] and data[k], k=0 (input side) .. DEPTH-1 (output side).
- Reset: all valid[k]=0, all data[k]=0. out_valid=0 and out_data=0 after the reset edge. in_ready=0 while rst=1, 1 after release.
- Stage movement (combinational):
  - move[DEPTH-1] = valid[DEPTH-1] & out_ready
  - move[k] = valid[k] & (~valid[k+1] | move[k+1])
  - ready[k] = ~valid[k] | move[k]
  - in_ready = ready[0] & ~flush & ~rst
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage update on edge:
  - If ready[k]: valid[k] <= upstream valid (in_valid for k=0, else valid[k-1]).
  - data[k] loads only when ready[k] and the upstream valid is 1; otherwise data[k] holds.
- Latency: a word accepted on edge n is on out_data with out_valid=1 after edge n+DEPTH-1, assuming no stall. Throughput: 1 word/cycle.
- Bubble collapsing: an empty stage is filled even while downstream stages are stalled. DEPTH words can be held with out_ready=0.
- Full: all valid=1 and out_ready=0 gives in_ready=0. Simultaneous input and output transfers when full are allowed (in_ready=1 when out_ready=1).
- Empty: out_valid=0 and out_data holds its last value.
- Flush:
  - out_valid forced to 0 in the flush cycle; no output transfer occurs.
  - All valid[k] cleared on the edge; in_ready=0, so no input is accepted.
  - data[k] is not cleared.
- Priority: rst > flush > normal operation. Reset mid-stream drops all words, same as flush but data is also zeroed.
- Ordering: words exit strictly in acceptance order, no loss, no duplication.
- out_valid must not depend combinationally on out_ready. out_data is stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: ELASTIC_PIPE_OCCUPANCY_EN.
- Defined: adds output port occupancy, width $clog2(DEPTH+1), equal to the popcount of valid[] (from registers, no input dependence).
  - 0 after reset and after flush; DEPTH when full.
  - Updates on the same edge as the valid bits.
- Undefined: port and logic absent; the rest of the behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xAA -> in_ready=0 during reset. After release: out_valid=0, out_data=0x00, in_ready=1, occupancy=0.
- Streaming (WIDTH=8, DEPTH=4, out_ready=1): send 0x01..0x08 back-to-back -> 0x01 appears after edge n+3, then one word per cycle in order; in_ready stays 1.
- Backpressure: out_ready=0, offer 0x10..0x15 -> exactly 4 accepted, then in_ready=0 and occupancy=4; out_data holds 0x10. Raise out_ready -> 0x10..0x13 exit, then 0x14, 0x15, with no loss or duplication.
- Bubble collapse: out_ready=0; send 0x21, idle 2 cycles, send 0x22 -> 0x22 lands in stage 2 directly behind 0x21, occupancy=2. Set out_ready=1 -> 0x21 and 0x22 exit on consecutive cycles.
- Flush: 3 words in flight, flush=1 with in_valid=1, in_data=0x99 -> out_valid=0 and in_ready=0 in that cycle; occupancy=0 next cycle; 0x99 never exits. A following 0x55 exits after normal latency.
- Full with simultaneous transfers: pipe full, out_ready=1, in_valid=1 -> in_ready=1, occupancy stays 4, order preserved. Then assert rst mid-stream -> all valid and data return to 0 on that edge.
